// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of the 5-stage MIPS core, sitting just upstream of
// the ALU. Captures decoded operands and control each cycle. It holds them
// while stalled and loads a bubble on flush. Combinationally, it applies
// EX/MEM and MEM/WB forwarding plus the immediate select, so data1/data2/
// ALUControl are ready for the ALU. It also raises the load-use hazard flag.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   stall, flush        hold all fields / load a bubble (flush wins)
//   id_*                decoded instruction from the ID stage
//   ex_mem_*, mem_wb_*  forwarding sources from the downstream stages
//   data1, data2        ALU operands (forwarded, immediate-selected)
//   ALUControl          registered ALU operation
//   store_data          forwarded rt value, used as sw data
//   write_reg           destination register index
//   ex_valid, ex_*      registered valid and downstream controls
//   load_use_hazard     stall request toward ID/IF
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [3:0]    id_alu_control,
    input  logic          id_alusrc,
    input  logic          id_regdst,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          ex_mem_regwrite,
    input  logic [RW-1:0] ex_mem_rd,
    input  logic [DW-1:0] ex_mem_result,
    input  logic          mem_wb_regwrite,
    input  logic [RW-1:0] mem_wb_rd,
    input  logic [DW-1:0] mem_wb_result,
    output logic [DW-1:0] data1,
    output logic [DW-1:0] data2,
    output logic [3:0]    ALUControl,
    output logic [DW-1:0] store_data,
    output logic [RW-1:0] write_reg,
    output logic          ex_valid,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic          load_use_hazard
);

    // Registered pipeline fields
    logic          valid_reg;
    logic [DW-1:0] rs_data_reg;
    logic [DW-1:0] rt_data_reg;
    logic [DW-1:0] imm_reg;
    logic [RW-1:0] rs_reg;
    logic [RW-1:0] rt_reg;
    logic [RW-1:0] write_reg_reg;
    logic [3:0]    alu_control_reg;
    logic          alusrc_reg;
    logic          regwrite_reg;
    logic          memread_reg;
    logic          memwrite_reg;
    logic          memtoreg_reg;

    // Destination is resolved at capture so later stages only see one index.
    // Control bits of an invalid instruction are cleared so it behaves as a bubble.
    logic [RW-1:0] write_reg_next;
    logic          regwrite_next;
    logic          memread_next;
    logic          memwrite_next;
    logic          memtoreg_next;

    assign write_reg_next = id_regdst ? id_rd : id_rt;
    assign regwrite_next  = id_valid & id_regwrite;
    assign memread_next   = id_valid & id_memread;
    assign memwrite_next  = id_valid & id_memwrite;
    assign memtoreg_next  = id_valid & id_memtoreg;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_reg       <= 1'b0;
            rs_data_reg     <= '0;
            rt_data_reg     <= '0;
            imm_reg         <= '0;
            rs_reg          <= '0;
            rt_reg          <= '0;
            write_reg_reg   <= '0;
            alu_control_reg <= '0;
            alusrc_reg      <= 1'b0;
            regwrite_reg    <= 1'b0;
            memread_reg     <= 1'b0;
            memwrite_reg    <= 1'b0;
            memtoreg_reg    <= 1'b0;
        end else if (!stall) begin
            valid_reg       <= id_valid;
            rs_data_reg     <= id_rs_data;
            rt_data_reg     <= id_rt_data;
            imm_reg         <= id_imm;
            rs_reg          <= id_rs;
            rt_reg          <= id_rt;
            write_reg_reg   <= write_reg_next;
            alu_control_reg <= id_alu_control;
            alusrc_reg      <= id_alusrc;
            regwrite_reg    <= regwrite_next;
            memread_reg     <= memread_next;
            memwrite_reg    <= memwrite_next;
            memtoreg_reg    <= memtoreg_next;
        end
    end

    // Forwarding: index 0 is operand A (rs), index 1 is operand B (rt).
    // The younger EX/MEM result wins over MEM/WB. Register 0 is never forwarded.
    logic [1:0][RW-1:0] src_idx;
    logic [1:0][DW-1:0] src_data;
    logic [1:0][DW-1:0] fwd;

    assign src_idx[0]  = rs_reg;
    assign src_idx[1]  = rt_reg;
    assign src_data[0] = rs_data_reg;
    assign src_data[1] = rt_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic ex_hit;
            logic wb_hit;
            assign ex_hit  = ex_mem_regwrite && (ex_mem_rd == src_idx[gi]) && (src_idx[gi] != '0);
            assign wb_hit  = mem_wb_regwrite && (mem_wb_rd == src_idx[gi]) && (src_idx[gi] != '0);
            assign fwd[gi] = ex_hit ? ex_mem_result :
                             wb_hit ? mem_wb_result : src_data[gi];
        end
    endgenerate

    assign data1       = fwd[0];
    assign data2       = alusrc_reg ? imm_reg : fwd[1];
    assign store_data  = fwd[1];
    assign ALUControl  = alu_control_reg;
    assign write_reg   = write_reg_reg;
    assign ex_valid    = valid_reg;
    assign ex_regwrite = regwrite_reg;
    assign ex_memread  = memread_reg;
    assign ex_memwrite = memwrite_reg;
    assign ex_memtoreg = memtoreg_reg;

    // A load in EX whose result is needed by the instruction now in ID.
    // rt only counts as a source when ID does not take the immediate.
    assign load_use_hazard = valid_reg && memread_reg && (write_reg_reg != '0) &&
                             ((write_reg_reg == id_rs) ||
                              ((write_reg_reg == id_rt) && !id_alusrc));

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset, stall, flush;
    logic          id_valid;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [3:0]    id_alu_control;
    logic          id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic          ex_mem_regwrite;
    logic [RW-1:0] ex_mem_rd;
    logic [DW-1:0] ex_mem_result;
    logic          mem_wb_regwrite;
    logic [RW-1:0] mem_wb_rd;
    logic [DW-1:0] mem_wb_result;
    logic [DW-1:0] data1, data2, store_data;
    logic [3:0]    ALUControl;
    logic [RW-1:0] write_reg;
    logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic          load_use_hazard;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_control(id_alu_control), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg),
        .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd), .ex_mem_result(ex_mem_result),
        .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result),
        .data1(data1), .data2(data2), .ALUControl(ALUControl), .store_data(store_data),
        .write_reg(write_reg), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .load_use_hazard(load_use_hazard)
    );

    // ---------------- reference model: the instruction sitting in EX ----------------
    typedef struct {
        logic          valid;
        logic [DW-1:0] a_val, b_val, imm;
        logic [RW-1:0] a_reg, b_reg, dest;
        logic [3:0]    op;
        logic          use_imm, rw, mr, mw, mt;
    } instr_t;

    instr_t ex_instr;

    function automatic instr_t bubble();
        instr_t b;
        b.valid = 0; b.a_val = 0; b.b_val = 0; b.imm = 0;
        b.a_reg = 0; b.b_reg = 0; b.dest = 0; b.op = 0;
        b.use_imm = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.mt = 0;
        return b;
    endfunction

    function automatic instr_t decoded_id();
        instr_t d;
        d.valid = id_valid; d.a_val = id_rs_data; d.b_val = id_rt_data; d.imm = id_imm;
        d.a_reg = id_rs; d.b_reg = id_rt;
        d.dest  = id_regdst ? id_rd : id_rt;
        d.op    = id_alu_control; d.use_imm = id_alusrc;
        d.rw = id_valid && id_regwrite; d.mr = id_valid && id_memread;
        d.mw = id_valid && id_memwrite; d.mt = id_valid && id_memtoreg;
        return d;
    endfunction

    // Value of an architectural register as seen by EX: scan producers from
    // youngest to oldest; fall back to the register-file read.
    function automatic logic [DW-1:0] reg_value(input logic [RW-1:0] r, input logic [DW-1:0] rf);
        logic          we  [2];
        logic [RW-1:0] dst [2];
        logic [DW-1:0] val [2];
        we[0] = ex_mem_regwrite; dst[0] = ex_mem_rd; val[0] = ex_mem_result;
        we[1] = mem_wb_regwrite; dst[1] = mem_wb_rd; val[1] = mem_wb_result;
        if (r == 0) return rf;
        for (int i = 0; i < 2; i++)
            if (we[i] && dst[i] == r) return val[i];
        return rf;
    endfunction

    function automatic logic model_hazard();
        logic needs;
        needs = (ex_instr.dest == id_rs) || (ex_instr.dest == id_rt && !id_alusrc);
        return ex_instr.valid && ex_instr.mr && ex_instr.dest != 0 && needs;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset || flush) ex_instr = bubble();
        else if (!stall)    ex_instr = decoded_id();
        #1;
    endtask

    task automatic check_model(input int cyc);
        logic [DW-1:0] b;
        b = reg_value(ex_instr.b_reg, ex_instr.b_val);
        chk("rnd_data1", data1, reg_value(ex_instr.a_reg, ex_instr.a_val));
        chk("rnd_data2", data2, ex_instr.use_imm ? ex_instr.imm : b);
        chk("rnd_store", store_data, b);
        chk("rnd_aluc", 32'(ALUControl), 32'(ex_instr.op));
        chk("rnd_wreg", 32'(write_reg), 32'(ex_instr.dest));
        chk("rnd_ctrl", {27'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
            {27'd0, ex_instr.valid, ex_instr.rw, ex_instr.mr, ex_instr.mw, ex_instr.mt});
        chk("rnd_hazard", 32'(load_use_hazard), 32'(model_hazard()));
        if (cyc % 50 == 0)
            $display("rnd cycle %0d: data1=%h data2=%h wreg=%0d hz=%b", cyc, data1, data2, write_reg, load_use_hazard);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; reset = 0;
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_alu_control = 0;
        id_alusrc = 0; id_regdst = 0; id_regwrite = 0; id_memread = 0;
        id_memwrite = 0; id_memtoreg = 0;
        ex_mem_regwrite = 0; ex_mem_rd = 0; ex_mem_result = 0;
        mem_wb_regwrite = 0; mem_wb_rd = 0; mem_wb_result = 0;
    endtask

    task automatic random_id();
        id_valid = 1'($urandom); id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
        id_rd = 5'($urandom_range(0, 7)); id_alu_control = 4'($urandom);
        id_alusrc = 1'($urandom); id_regdst = 1'($urandom); id_regwrite = 1'($urandom);
        id_memread = 1'($urandom); id_memwrite = 1'($urandom); id_memtoreg = 1'($urandom);
    endtask

    task automatic random_fwd();
        ex_mem_regwrite = 1'($urandom); ex_mem_rd = 5'($urandom_range(0, 7)); ex_mem_result = $urandom;
        mem_wb_regwrite = 1'($urandom); mem_wb_rd = 5'($urandom_range(0, 7)); mem_wb_result = $urandom;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          valid;
        logic [31:0]   rs_data, rt_data, imm;
        logic [4:0]    rs, rt, rd;
        logic [3:0]    aluc;
        logic          alusrc, regdst, rw, mr;
        logic          exw; logic [4:0] exrd; logic [31:0] exres;
        logic          mww; logic [4:0] mwrd; logic [31:0] mwres;
        logic [31:0]   e_d1, e_d2, e_st;
        logic [3:0]    e_aluc;
        logic [4:0]    e_wr;
        logic          e_ev, e_rw, e_mr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // basic capture (sub, rd destination)
        vecs[0] = '{1'b1, 32'd5, 32'd3, 32'd0, 5'd1, 5'd2, 5'd9, 4'b0110, 1'b0, 1'b1, 1'b1, 1'b0,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                    32'd5, 32'd3, 32'd3, 4'b0110, 5'd9, 1'b1, 1'b1, 1'b0};
        // invalid instruction: controls squashed, rt destination
        vecs[1] = '{1'b0, 32'd7, 32'd8, 32'd0, 5'd1, 5'd3, 5'd10, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                    32'd7, 32'd8, 32'd8, 4'b0010, 5'd3, 1'b0, 1'b0, 1'b0};
        // immediate select, rt forwarded from MEM/WB into store_data, r0 never forwarded
        vecs[2] = '{1'b1, 32'd11, 32'd1, 32'hFFFFFFF0, 5'd0, 5'd6, 5'd0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1,
                    1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd6, 32'h77,
                    32'd11, 32'hFFFFFFF0, 32'h77, 4'b0010, 5'd6, 1'b1, 1'b1, 1'b1};
        // both stages match: EX/MEM wins
        vecs[3] = '{1'b1, 32'd1, 32'd2, 32'd0, 5'd4, 5'd4, 5'd12, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0,
                    1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB,
                    32'hAA, 32'hAA, 32'hAA, 4'b0000, 5'd12, 1'b1, 1'b1, 1'b0};
        // only MEM/WB writes
        vecs[4] = '{1'b1, 32'd1, 32'd2, 32'd0, 5'd4, 5'd4, 5'd12, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0,
                    1'b0, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB,
                    32'hBB, 32'hBB, 32'hBB, 4'b0000, 5'd12, 1'b1, 1'b1, 1'b0};
        // split: A from MEM/WB, B from EX/MEM
        vecs[5] = '{1'b1, 32'd1, 32'd2, 32'd0, 5'd5, 5'd4, 5'd13, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b1, 5'd4, 32'hAA, 1'b1, 5'd5, 32'hCC,
                    32'hCC, 32'hAA, 32'hAA, 4'b0001, 5'd13, 1'b1, 1'b0, 1'b0};
        // slt with immediate; forwarded rt only reaches store_data
        vecs[6] = '{1'b1, 32'd9, 32'd4, 32'd5, 5'd0, 5'd7, 5'd1, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b0,
                    1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hEE,
                    32'd9, 32'd5, 32'hEE, 4'b0111, 5'd7, 1'b1, 1'b1, 1'b0};
    end

    // ---------------- test sequence ----------------
    initial begin
        ex_instr = bubble();
        idle_inputs();

        // Reset with random inputs
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            random_id(); random_fwd();
            tick();
        end
        chk("reset_data1", data1, 32'd0);
        chk("reset_data2", data2, 32'd0);
        chk("reset_store", store_data, 32'd0);
        chk("reset_aluc", 32'(ALUControl), 32'd0);
        chk("reset_wreg", 32'(write_reg), 32'd0);
        chk("reset_ctrl", {27'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}, 32'd0);
        chk("reset_hazard", 32'(load_use_hazard), 32'd0);
        $display("reset: data1=%h data2=%h ex_valid=%b", data1, data2, ex_valid);
        idle_inputs();

        // Table-driven vectors
        for (int v = 0; v < 7; v++) begin
            id_valid = vecs[v].valid; id_rs_data = vecs[v].rs_data; id_rt_data = vecs[v].rt_data;
            id_imm = vecs[v].imm; id_rs = vecs[v].rs; id_rt = vecs[v].rt; id_rd = vecs[v].rd;
            id_alu_control = vecs[v].aluc; id_alusrc = vecs[v].alusrc; id_regdst = vecs[v].regdst;
            id_regwrite = vecs[v].rw; id_memread = vecs[v].mr;
            ex_mem_regwrite = vecs[v].exw; ex_mem_rd = vecs[v].exrd; ex_mem_result = vecs[v].exres;
            mem_wb_regwrite = vecs[v].mww; mem_wb_rd = vecs[v].mwrd; mem_wb_result = vecs[v].mwres;
            tick();
            chk($sformatf("vec%0d_data1", v), data1, vecs[v].e_d1);
            chk($sformatf("vec%0d_data2", v), data2, vecs[v].e_d2);
            chk($sformatf("vec%0d_store", v), store_data, vecs[v].e_st);
            chk($sformatf("vec%0d_aluc", v), 32'(ALUControl), 32'(vecs[v].e_aluc));
            chk($sformatf("vec%0d_wreg", v), 32'(write_reg), 32'(vecs[v].e_wr));
            chk($sformatf("vec%0d_ctrl", v), {29'd0, ex_valid, ex_regwrite, ex_memread},
                {29'd0, vecs[v].e_ev, vecs[v].e_rw, vecs[v].e_mr});
            $display("vec%0d: data1=%h data2=%h store=%h aluc=%b wreg=%0d valid=%b",
                     v, data1, data2, store_data, ALUControl, write_reg, ex_valid);
        end
        idle_inputs();

        // rs = rt = 0 with both stages claiming r0: no forward
        id_valid = 1; ex_mem_regwrite = 1; ex_mem_rd = 0; ex_mem_result = 32'hAA;
        mem_wb_regwrite = 1; mem_wb_rd = 0; mem_wb_result = 32'hBB;
        tick();
        chk("r0_data1", data1, 32'd0);
        chk("r0_data2", data2, 32'd0);
        $display("r0: data1=%h data2=%h", data1, data2);
        idle_inputs();

        // Stall holds instruction A; then stall+flush gives a bubble
        id_valid = 1; id_rs = 1; id_rs_data = 32'h100; id_rt = 2; id_rt_data = 32'h200;
        id_alu_control = 4'b0010; id_regdst = 1; id_rd = 7; id_regwrite = 1;
        tick();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            random_id();
            tick();
            chk("stall_data1", data1, 32'h100);
            chk("stall_data2", data2, 32'h200);
            chk("stall_aluc", 32'(ALUControl), 32'd2);
            chk("stall_wreg", 32'(write_reg), 32'd7);
            chk("stall_ctrl", {30'd0, ex_valid, ex_regwrite}, 32'd3);
            $display("stall %0d: data1=%h data2=%h wreg=%0d", k, data1, data2, write_reg);
        end
        ex_mem_regwrite = 1; ex_mem_rd = 1; ex_mem_result = 32'h5A;
        #1;
        chk("stall_fwd_live", data1, 32'h5A);
        ex_mem_regwrite = 0;
        flush = 1;
        tick();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_ctrl", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}, 32'd0);
        chk("flush_data1", data1, 32'd0);
        chk("flush_wreg", 32'(write_reg), 32'd0);
        $display("stall+flush: valid=%b data1=%h wreg=%0d", ex_valid, data1, write_reg);
        idle_inputs();

        // Load-use hazard
        id_valid = 1; id_memread = 1; id_regwrite = 1; id_memtoreg = 1; id_regdst = 0;
        id_rt = 8; id_alusrc = 1; id_alu_control = 4'b0010;
        tick();
        id_memread = 0; id_alusrc = 0; id_rs = 8; id_rt = 3;
        #1; chk("lu_rs_match", 32'(load_use_hazard), 32'd1);
        id_rs = 2; id_rt = 8; id_alusrc = 1;
        #1; chk("lu_rt_imm", 32'(load_use_hazard), 32'd0);
        id_alusrc = 0;
        #1; chk("lu_rt_match", 32'(load_use_hazard), 32'd1);
        $display("load-use: write_reg=%0d hazard=%b", write_reg, load_use_hazard);
        // lw to r0
        id_memread = 1; id_rt = 0; id_alusrc = 1;
        tick();
        id_memread = 0; id_rs = 0; id_rt = 0; id_alusrc = 0;
        #1; chk("lu_r0", 32'(load_use_hazard), 32'd0);
        // lw r8 again, then flush clears the flag
        id_memread = 1; id_rt = 8; id_alusrc = 1;
        tick();
        id_memread = 0; id_rs = 8; id_alusrc = 0;
        #1; chk("lu_pre_flush", 32'(load_use_hazard), 32'd1);
        flush = 1;
        tick();
        flush = 0;
        #1; chk("lu_after_flush", 32'(load_use_hazard), 32'd0);
        $display("load-use after flush: hazard=%b", load_use_hazard);
        idle_inputs();

        // Randomized run against the model
        for (int c = 0; c < 400; c++) begin
            random_id(); random_fwd();
            reset = ($urandom_range(0, 31) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            #1;
            check_model(c);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
